mem_stage: RTL and testbench

Memory-access stage of the 64-bit in-order pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register `reg_MW`, consuming `execute_data_t` and producing `memory_data_t` plus `Dwait`. For loads and stores it drives a single-outstanding data-bus transaction, builds store strobes, and sign- or zero-extends load data. It also holds a completed response while the pipeline is stalled for another reason, so the access is never reissued.

---
 rtl/common.sv | 71 +++++++
 rtl/mem_align.sv | 48 ++++
 rtl/mem_stage.sv | 103 ++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// rtl/common.sv - shared pipeline types for the 64-bit in-order core
package common;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  // Byte-enable masks for an access of each size at offset 0
  localparam logic [7:0] MSIZE1_MASK = 8'h01;
  localparam logic [7:0] MSIZE2_MASK = 8'h03;
  localparam logic [7:0] MSIZE4_MASK = 8'h0F;
  localparam logic [7:0] MSIZE8_MASK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mstate_t;

  typedef struct packed {
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    msize_t msize;
    logic   mem_unsigned;
  } control_t;

  typedef struct packed {
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] srcb;
    logic        is_bubble;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic        is_bubble;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic [7:0] msize_mask(input msize_t s);
    case (s)
      MSIZE1:  return MSIZE1_MASK;
      MSIZE2:  return MSIZE2_MASK;
      MSIZE4:  return MSIZE4_MASK;
      default: return MSIZE8_MASK;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane shifting and load extract/extend
module mem_align
  import common::*;
(
  input  logic [2:0]  i_off,
  input  msize_t      i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_strobe,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata,
  output logic        o_aligned
);

  logic [5:0]  w_shamt;
  logic [63:0] w_raw;

  assign w_shamt  = {i_off, 3'b000};
  assign o_strobe = msize_mask(i_size) << i_off;
  assign o_wdata  = i_wdata << w_shamt;
  assign w_raw    = i_rdata >> w_shamt;

  // Natural alignment check and sign/zero extension of the addressed lanes
  always_comb begin
    o_aligned = 1'b1;
    o_rdata   = w_raw;
    case (i_size)
      MSIZE1: begin
        o_aligned = 1'b1;
        o_rdata   = i_unsigned ? {56'd0, w_raw[7:0]} : {{56{w_raw[7]}}, w_raw[7:0]};
      end
      MSIZE2: begin
        o_aligned = ~i_off[0];
        o_rdata   = i_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      end
      MSIZE4: begin
        o_aligned = (i_off[1:0] == 2'b00);
        o_rdata   = i_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      end
      default: begin
        o_aligned = (i_off == 3'b000);
        o_rdata   = w_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with single-outstanding data bus
module mem_stage
  import common::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE_in,
  input  logic          Iwait,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM_out,
  output logic          Dwait
);

  mstate_t     r_state;
  mstate_t     w_next_state;
  logic [63:0] r_rdata_q;

  logic [7:0]  w_strobe;
  logic [63:0] w_wdata;
  logic [63:0] w_ld_ext;
  logic        w_aligned;
  logic        w_is_mem;
  logic        w_memop;
  logic        w_req_valid;
  logic        w_unused;

  mem_align u_align (
    .i_off      (dataE_in.result[2:0]),
    .i_size     (dataE_in.ctl.msize),
    .i_unsigned (dataE_in.ctl.mem_unsigned),
    .i_wdata    (dataE_in.srcb),
    .i_rdata    (dresp.data),
    .o_strobe   (w_strobe),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ld_ext),
    .o_aligned  (w_aligned)
  );

  assign w_is_mem = ~dataE_in.is_bubble & (dataE_in.ctl.mem_read | dataE_in.ctl.mem_write);
  assign w_memop  = w_is_mem & w_aligned;
  // Reset masks the request so it falls without waiting for a clock edge
  assign w_req_valid = w_memop & (r_state != HOLD) & ~reset;
  // Completion handshake is data_ok only
  assign w_unused = dresp.addr_ok;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic and bus/stall outputs
  always_comb begin
    w_next_state = r_state;
    dreq         = '0;
    Dwait        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          if (!dresp.data_ok) w_next_state = WAIT;
          else if (Iwait)     w_next_state = HOLD;
          else                w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (dresp.data_ok) w_next_state = Iwait ? HOLD : IDLE;
      end
      HOLD: begin
        if (!Iwait) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    dreq.valid  = w_req_valid;
    dreq.addr   = dataE_in.result;
    dreq.size   = dataE_in.ctl.msize;
    dreq.strobe = dataE_in.ctl.mem_write ? w_strobe : 8'h00;
    dreq.data   = w_wdata;
    Dwait       = w_memop & ~dresp.data_ok & (r_state != HOLD) & ~reset;
  end

  // Capture load data on completion so a stalled instruction keeps its value
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rdata_q <= '0;
    else if (dresp.data_ok && w_req_valid && dataE_in.ctl.mem_read)
      r_rdata_q <= w_ld_ext;
  end

  // Result mux toward reg_MW
  always_comb begin
    dataM_out.pc        = dataE_in.pc;
    dataM_out.ctl       = dataE_in.ctl;
    dataM_out.dst       = dataE_in.dst;
    dataM_out.is_bubble = dataE_in.is_bubble;
    dataM_out.result    = dataE_in.result;
    if (w_is_mem && !w_aligned && dataE_in.ctl.mem_read)
      dataM_out.result = '0;
    else if (w_memop && dataE_in.ctl.mem_read)
      dataM_out.result = (r_state == HOLD) ? r_rdata_q : w_ld_ext;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;
  import common::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE_in;
  logic          Iwait;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM_out;
  logic          Dwait;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk       (clk),
    .reset     (reset),
    .dataE_in  (dataE_in),
    .Iwait     (Iwait),
    .dreq      (dreq),
    .dresp     (dresp),
    .dataM_out (dataM_out),
    .Dwait     (Dwait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input msize_t s);
    return 1 << int'(s);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] d, input int off, input int nb, input bit uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nb; i++)
      v = v | (((d >> (8 * (off + i))) & 64'hFF) << (8 * i));
    if (!uns && v[8 * nb - 1])
      for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_op(input bit rd, input bit wr, input bit bubble, input msize_t sz,
                          input bit uns, input logic [63:0] addr, input logic [63:0] srcb);
    dataE_in                  = '0;
    dataE_in.pc               = rand64();
    dataE_in.dst              = 5'($urandom);
    dataE_in.ctl.reg_write    = rd;
    dataE_in.ctl.mem_read     = rd;
    dataE_in.ctl.mem_write    = wr;
    dataE_in.ctl.msize        = sz;
    dataE_in.ctl.mem_unsigned = uns;
    dataE_in.result           = addr;
    dataE_in.srcb             = srcb;
    dataE_in.is_bubble        = bubble;
  endtask

  // Aligned access: n_wait cycles before data_ok, then n_stall cycles held by Iwait
  task automatic run_mem(input bit rd, input msize_t sz, input bit uns, input logic [63:0] addr,
                         input logic [63:0] srcb, input logic [63:0] rdata,
                         input int n_wait, input int n_stall);
    int          nb;
    int          off;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
    logic [63:0] exp_res;
    nb       = size_bytes(sz);
    off      = int'(addr[2:0]);
    exp_strb = rd ? 8'h00 : 8'(((1 << nb) - 1) << off);
    exp_data = srcb << (8 * off);
    exp_res  = rd ? ref_load(rdata, off, nb, uns) : addr;
    drive_op(rd, !rd, 1'b0, sz, uns, addr, srcb);
    for (int c = 0; c < n_wait; c++) begin
      dresp.data_ok = 1'b0;
      dresp.data    = rand64();
      Iwait         = 1'($urandom);
      @(negedge clk);
      check("wait_valid", 64'(dreq.valid), 64'd1);
      check("wait_dwait", 64'(Dwait), 64'd1);
      check("wait_addr", dreq.addr, addr);
      check("wait_strobe", 64'(dreq.strobe), 64'(exp_strb));
      if (!rd) check("wait_wdata", dreq.data, exp_data);
      @(posedge clk); #1;
    end
    dresp.data_ok = 1'b1;
    dresp.data    = rdata;
    Iwait         = (n_stall > 0);
    @(negedge clk);
    check("ok_valid", 64'(dreq.valid), 64'd1);
    check("ok_dwait", 64'(Dwait), 64'd0);
    check("ok_size", 64'(dreq.size), 64'(sz));
    check("ok_strobe", 64'(dreq.strobe), 64'(exp_strb));
    if (!rd) check("ok_wdata", dreq.data, exp_data);
    check("ok_result", dataM_out.result, exp_res);
    check("ok_pc", dataM_out.pc, dataE_in.pc);
    check("ok_dst", 64'(dataM_out.dst), 64'(dataE_in.dst));
    @(posedge clk); #1;
    for (int s = 1; s <= n_stall; s++) begin
      dresp.data_ok = 1'($urandom);
      dresp.data    = rand64();
      Iwait         = (s < n_stall);
      @(negedge clk);
      check("hold_valid", 64'(dreq.valid), 64'd0);
      check("hold_dwait", 64'(Dwait), 64'd0);
      check("hold_result", dataM_out.result, exp_res);
      @(posedge clk); #1;
    end
    dresp.data_ok = 1'b0;
    Iwait         = 1'b0;
  endtask

  // Single-cycle op that must not touch the bus: misaligned, bubble or non-memory
  task automatic run_nomem(input bit rd, input bit wr, input bit bubble, input msize_t sz,
                           input bit uns, input logic [63:0] addr);
    logic [63:0] exp_res;
    exp_res = (!bubble && rd) ? 64'd0 : addr;
    drive_op(rd, wr, bubble, sz, uns, addr, rand64());
    dresp.data_ok = 1'($urandom);
    dresp.data    = rand64();
    Iwait         = 1'b0;
    @(negedge clk);
    check("nomem_valid", 64'(dreq.valid), 64'd0);
    check("nomem_dwait", 64'(Dwait), 64'd0);
    check("nomem_result", dataM_out.result, exp_res);
    @(posedge clk); #1;
    dresp.data_ok = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    Iwait    = 1'b0;
    dresp    = '0;
    drive_op(1'b1, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h8000_0000, 64'd0);
    #1;
    check("rst_valid", 64'(dreq.valid), 64'd0);
    check("rst_dwait", 64'(Dwait), 64'd0);
    check("rst_rdata_q", dut.r_rdata_q, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases
    run_mem(1'b0, MSIZE4, 1'b0, 64'h8000_0004, 64'h1122_3344, rand64(), 2, 0);
    run_mem(1'b1, MSIZE1, 1'b0, 64'h8000_0001, rand64(), 64'h0000_0000_0000_80FF, 1, 0);
    run_mem(1'b1, MSIZE1, 1'b1, 64'h8000_0001, rand64(), 64'h0000_0000_0000_80FF, 0, 0);
    run_mem(1'b1, MSIZE2, 1'b0, 64'h8000_0000, rand64(), 64'h0000_0000_0000_80FF, 0, 0);
    run_mem(1'b1, MSIZE8, 1'b0, 64'h8000_0010, rand64(), 64'hDEAD_BEEF_0BAD_F00D, 3, 4);
    run_nomem(1'b1, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h8000_0004);
    run_nomem(1'b0, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_0004);
    run_nomem(1'b1, 1'b0, 1'b1, MSIZE4, 1'b0, 64'h8000_0008);

    // Reset in the middle of a pending load
    drive_op(1'b1, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h8000_0020, 64'd0);
    dresp.data_ok = 1'b0;
    @(negedge clk);
    check("pre_rst_dwait", 64'(Dwait), 64'd1);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(dreq.valid), 64'd0);
    check("async_rst_rdata_q", dut.r_rdata_q, 64'd0);
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    drive_op(1'b0, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h8000_0020, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    dresp.data_ok = 1'b0;
    check("post_rst_rdata_q", dut.r_rdata_q, 64'd0);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      msize_t      sz;
      int          nb;
      logic [63:0] addr;
      int          kind;
      sz   = msize_t'($urandom_range(0, 3));
      nb   = size_bytes(sz);
      addr = rand64() & ~64'(nb - 1);
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        run_mem(1'($urandom), sz, 1'($urandom), addr, rand64(), rand64(),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (kind == 7 && sz != MSIZE1) begin
        addr = addr | 64'($urandom_range(1, nb - 1));
        run_nomem(1'($urandom), 1'b0, 1'b0, sz, 1'($urandom), addr);
        run_nomem(1'b0, 1'b1, 1'b0, sz, 1'($urandom), addr);
      end else if (kind == 8) begin
        run_nomem(1'($urandom), 1'b1, 1'b1, sz, 1'($urandom), addr);
      end else begin
        run_nomem(1'b0, 1'b0, 1'($urandom), sz, 1'($urandom), addr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
